// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART subsystem.
//   UART_DATA_W   : width of one UART character
//   CLK_FREQ_HZ   : system clock frequency
//   BAUD_RATE     : serial line rate
//   CLOCK_PER_BIT : system clocks per serial bit (CLK_FREQ_HZ / BAUD_RATE)
//   uart_byte_t   : one received/transmitted character
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int CLK_FREQ_HZ   = 100_000_000;
  localparam int BAUD_RATE     = 9600;
  localparam int CLOCK_PER_BIT = 10416;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/fifo_regfile.sv
// ----------------------------------------------------------------------------
// fifo_regfile
// DEPTH x DATA_W storage array with one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk     : system clock
//   i_we    : write enable, writes i_wdata at i_waddr on the rising edge
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : contents of the entry at i_raddr (combinational)
// ----------------------------------------------------------------------------
module fifo_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fifo_regfile

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer sitting behind the UART receiver. Each rx_done
// pulse pushes rx_data; the consumer pops with rd_en. Reports occupancy,
// empty/full/almost_full (registered) and a sticky overflow flag.
//
// Build option:
//   UART_RX_FIFO_FWFT_EN defined   : first-word-fall-through. rd_data shows the
//                                    head byte whenever not empty, rd_valid =
//                                    ~empty, rd_en removes the displayed byte.
//   UART_RX_FIFO_FWFT_EN undefined : standard mode. A pop at edge N drives the
//                                    popped byte on rd_data with a one-cycle
//                                    rd_valid pulse after edge N; rd_data holds
//                                    its last value otherwise.
//
// Ports:
//   clk         : system clock (100 MHz)
//   rst         : asynchronous active-low reset
//   rx_data     : byte from the receiver, valid while rx_done=1
//   rx_done     : one-cycle push strobe
//   rd_en       : consumer pop request
//   rd_data     : output byte (timing per build option)
//   rd_valid    : rd_data is valid this cycle
//   empty       : count == 0
//   full        : count == DEPTH
//   almost_full : count >= AFULL_TH
//   count       : current occupancy, 0..DEPTH
//   overflow    : sticky, set by a push that had to be dropped
//   clr         : synchronous flush, also clears overflow
//
// Handshake: a byte is accepted on any edge where rx_done=1 and either the
// FIFO is not full or a pop happens on the same edge. A pop happens on any
// edge where rd_en=1 and the FIFO is not empty. clr overrides both.
// ----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_done,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL_TH = CW'(AFULL_TH);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_afull;
  logic              r_overflow;

  logic              w_pop;
  logic              w_push;
  logic              w_we;
  logic [AW-1:0]     w_wr_ptr_nxt;
  logic [AW-1:0]     w_rd_ptr_nxt;
  logic [CW-1:0]     w_count_nxt;
  logic              w_overflow_nxt;
  logic [DATA_W-1:0] w_rd_word;

  fifo_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (rx_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_word)
  );

  // Next-state for pointers, count and overflow. A pop on an empty FIFO is
  // ignored, so an empty push+pop is just a push (no bypass to rd_data).
  always_comb begin
    w_pop          = rd_en & ~r_empty;
    w_push         = rx_done & (~r_full | w_pop);
    w_we           = w_push & ~clr;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    if (clr) begin
      w_wr_ptr_nxt   = '0;
      w_rd_ptr_nxt   = '0;
      w_count_nxt    = '0;
      w_overflow_nxt = 1'b0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
      // Dropped byte: full and nothing leaving on this edge.
      if (rx_done & r_full & ~w_pop) begin
        w_overflow_nxt = 1'b1;
      end
    end
  end

  // Flags are computed from the next count so they are pure registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == C_DEPTH);
      r_afull    <= (w_count_nxt >= C_AFULL_TH);
      r_overflow <= w_overflow_nxt;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  // Head entry is shown straight from the array; forced to zero while empty
  // so stale storage never leaks onto the output.
  assign rd_data  = r_empty ? '0 : w_rd_word;
  assign rd_valid = ~r_empty;
`else
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (clr) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

  assign empty       = r_empty;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule : uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of the UART receiver in UART_top. Captures each received byte on the receiver's one-cycle rx_done pulse and holds it until the consumer pops it. Consumers include the command logic, the loopback path, and later the SoC bus bridge. Decouples 9600-baud byte arrival from consumer latency and reports fill level, almost-full and overflow.

Parameters:
DATA_W, 8, byte width; must match the receiver's rx_data width.
DEPTH, 16, number of entries; power of two, minimum 2.
AFULL_TH, 12, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately; deassertion is synchronous to clk.
rx_data  input  DATA_W  byte from the UART receiver; valid only while rx_done=1.
rx_done  input  1  one-cycle push strobe from the UART receiver.
rd_en  input  1  consumer pop request.
rd_data  output  DATA_W  head byte; timing depends on the optional feature.
rd_valid  output  1  rd_data is valid this cycle.
empty  output  1  count == 0.
full  output  1  count == DEPTH.
almost_full  output  1  count >= AFULL_TH.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky; set when a push arrives while full.
clr  input  1  synchronous flush; empties the FIFO and clears overflow.

Behaviour:
- Reset (rst=0): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, rd_valid=0, rd_data=0. Storage contents are not reset.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count is tracked by its own register, not derived from pointer difference.
- Push occurs when rx_done=1 and (not full, or a pop occurs in the same cycle). Data is written at wr_ptr, and wr_ptr increments.
- Push while full with no pop in the same cycle: byte is dropped, overflow is set, pointers and count are unchanged. overflow stays set until clr or reset.
- Pop occurs when rd_en=1 and not empty. rd_ptr increments.
- rd_en while empty is ignored: no pointer change, rd_valid=0. It is not an error.
- Push and pop in the same cycle:
  - Non-empty: count unchanged, both pointers advance.
  - Full: the push is accepted because the pop frees a slot; overflow is not set.
  - Empty: the pop is ignored and the push is accepted. Count goes 0 to 1. No bypass of the pushed byte to rd_data in that cycle.
- Flags (empty, full, almost_full) are registered. They reflect count after the clock edge: they update in the cycle after a push or pop.
- clr has priority over push and pop in the same cycle. After the edge: pointers=0, count=0, overflow=0, rd_valid=0. Any byte pushed in the clr cycle is discarded.
- Asynchronous reset mid-operation clears state immediately, regardless of clk. A rx_done pulse coinciding with reset deassertion is not guaranteed to be captured.
- rx_done is trusted to be a single-cycle pulse. A multi-cycle high pushes once per cycle; this is the receiver's responsibility, not checked here.

Optional Feature:
Macro: UART_RX_FIFO_FWFT_EN.
- Defined (first-word-fall-through): rd_data shows mem[rd_ptr] whenever empty=0, and rd_valid = ~empty. rd_en acknowledges and removes the displayed byte. Head-to-output latency is 0 cycles after empty deasserts.
- Undefined (standard mode): rd_data and rd_valid are registered. A pop at edge N puts the popped byte on rd_data with rd_valid=1 after edge N. rd_valid is a one-cycle pulse per pop. rd_data holds its last value otherwise.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W = 8.
  - CLK_FREQ_HZ = 100_000_000.
  - BAUD_RATE = 9600.
  - CLOCK_PER_BIT = 10416.
  - Typedef uart_byte_t for logic [UART_DATA_W-1:0].
- One sub-module, fifo_regfile: DEPTH x DATA_W storage with synchronous write and an asynchronous read port. It is instantiated once. Pointer, count and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> empty=1, full=0, count=0, overflow=0, rd_valid=0.
- Single byte: pulse rx_done with rx_data=8'h31, then rd_en -> count goes 1 then 0. rd_data=8'h31, arriving one cycle after rd_en in standard mode and before rd_en in FWFT mode.
- Fill and wrap: push 8'h00..8'h0F, pop all, push 8'h10..8'h14, pop all -> output order 00..0F then 10..14. full=1 at count=16. almost_full=1 from count=12.
- Overflow: at full (16 entries), push 8'hAA -> byte dropped, overflow=1, count=16. Then pop 16 entries -> 8'hAA never appears. Then clr -> overflow=0.
- Simultaneous: at full, rx_done=1 (8'h55) together with rd_en=1 -> count stays 16, overflow=0, 8'h55 read last. At empty, both strobes -> count=1, rd_valid=0 that cycle.
- End-to-end: drive UART_top rx line with 8'h31 at BIT_PERIOD=104160 ns (start bit, 8 data bits LSB first, stop bit) -> count=1 after rx_done; popped rd_data=8'h31.
